round_controller: RTL and testbench
===================================

Name: round_controller

Overview:
- Drives the countdown timer rather than consuming its ticks: it decides when the timer is held in reset and when it runs.
- Watches the timer's time_remaining and game_end to sequence a multi-round game: lead-in, play, hold, then next round or game over.
- Accumulates a time-bonus score and flags low-time warnings for the display.
- Sits between the input/answer-check logic and the timer; its outputs feed the display mux.

Parameters:
- ROUND_TIME, 20: seconds per round; must match the timer's load value. Used only for checks and the score bound.
- NUM_ROUNDS, 5: rounds per game, 1..15.
- LEAD_IN, 3: lead-in cycles before each round, 1..3.
- HOLD_CYCLES, 2: cycles the result is shown after a round ends, 1..7.
- WARN_THRESH, 5: warn is asserted when 0 < time_remaining <= WARN_THRESH.
- SCORE_W, 8: score width.

Ports:
- timer_clk  in  1  round tick clock (same clock as the timer)
- rst  in  1  synchronous, active-high reset
- start  in  1  level from the start button (debounced upstream); a rising edge is sampled on timer_clk
- solved  in  1  answer correct; upstream holds it high until round_num changes
- time_remaining  in  6  seconds left, from the timer
- game_end  in  1  timer expired, from the timer
- timer_rst  out  1  timer reset; the timer loads ROUND_TIME on any edge where this is high
- phase  out  3  current state encoding (see package)
- lead_count  out  2  lead-in countdown value for the display
- round_num  out  4  current round, 1-based; 0 when idle
- score  out  SCORE_W  accumulated score
- warn  out  1  low-time indicator
- done  out  1  game finished

Behaviour:
- Clocking and outputs:
  - All state and outputs are registered on posedge timer_clk.
  - rst is synchronous, active-high, on clock timer_clk.
  - rst dominates all other inputs.
- Reset values: phase=IDLE, timer_rst=1, round_num=0, score=0, lead_count=0, warn=0, done=0, start_q=0.
- Start detection:
  - start_q registers start every cycle.
  - start_rise = start & ~start_q. Only the rising edge acts; a held level does not retrigger.
- IDLE:
  - timer_rst=1.
  - On start_rise: go to LEAD_IN, lead_count=LEAD_IN, round_num=1, score=0.
- LEAD_IN:
  - timer_rst=1.
  - lead_count decrements each cycle.
  - In the cycle where lead_count==1: next state is PLAY, lead_count becomes 0, timer_rst becomes 0.
  - LEAD_IN therefore lasts exactly LEAD_IN cycles, and the timer holds ROUND_TIME on PLAY entry.
- PLAY:
  - timer_rst=0. Priority order: game_end, then solved.
  - If game_end=1: go to HOLD with no score change. This also applies when game_end and solved are high in the same cycle.
  - Else if solved=1: score += time_remaining, saturating at 2^SCORE_W-1; go to HOLD.
  - On entry to HOLD: timer_rst=1 and hold counter = HOLD_CYCLES.
  - warn (registered) = 1 iff in PLAY and 0 < time_remaining <= WARN_THRESH; warn=0 in every other state.
- HOLD:
  - timer_rst=1; the hold counter decrements each cycle.
  - At count 1: if round_num==NUM_ROUNDS, go to OVER and set done=1. Otherwise round_num+1, go to LEAD_IN, lead_count=LEAD_IN.
- OVER:
  - timer_rst=1, done=1; score and round_num are held.
  - On start_rise: same action as from IDLE (new game, score cleared, done=0).
- Boundary conditions:
  - solved arriving during LEAD_IN/HOLD/OVER/IDLE is ignored.
  - start_rise during LEAD_IN/PLAY/HOLD is ignored.
  - rst mid-round: next edge gives reset values; the timer is also reset because timer_rst=1.
  - time_remaining is taken as is; no width conversion beyond zero-extension to SCORE_W.
  - Score addition saturates and never wraps.
- Latency:
  - solved to score update: 1 cycle.
  - game_end to timer_rst high: 1 cycle.

Decomposition:
- Package round_pkg holds:
  - phase encoding: IDLE=0, LEAD_IN=1, PLAY=2, HOLD=3, OVER=4;
  - shared ROUND_TIME constant, also used by the timer;
  - SCORE_MAX.
- Sub-module rise_detect: 1-bit registered rising-edge detector (start_q, start_rise), with synchronous reset.
- The saturating add stays inline.

Test Plan:
- Reset, then start_rise: phase 0→1, lead_count 3,2,1, then PLAY with timer_rst=0 and round_num=1 on the 4th edge.
- PLAY, solved=1 at time_remaining=14: score 0→14 next edge, phase=HOLD, timer_rst=1; after 2 cycles LEAD_IN with round_num=2.
- PLAY, no solve: warn rises when time_remaining=5 and stays high through 1. On game_end, warn=0, score unchanged, phase=HOLD.
- solved=1 and game_end=1 in the same cycle: score unchanged, HOLD entered. Separately, with score preloaded to 250, solving at 10 gives 255 (saturated).
- 5 rounds completed: after the final HOLD, phase=OVER, done=1, held with start held high. Toggling start low then high starts a new game with score=0 and round_num=1.
- rst asserted mid-PLAY at time_remaining=9: next edge gives phase=IDLE, score=0, round_num=0, timer_rst=1, warn=0.

Source files
------------

// File: rtl/round_pkg.sv
// Shared constants for the round controller and the countdown timer.
// Phase encoding is visible on the phase output port.
package round_pkg;

    localparam logic [2:0] PH_IDLE    = 3'd0;
    localparam logic [2:0] PH_LEAD_IN = 3'd1;
    localparam logic [2:0] PH_PLAY    = 3'd2;
    localparam logic [2:0] PH_HOLD    = 3'd3;
    localparam logic [2:0] PH_OVER    = 3'd4;

    localparam int ROUND_TIME  = 20;
    localparam int SCORE_W_DEF = 8;

    function automatic int score_max(input int w);
        return (1 << w) - 1;
    endfunction

    localparam int SCORE_MAX = score_max(SCORE_W_DEF);

endpackage

// File: rtl/round_controller_rise_detect.sv
// Registered rising-edge detector with synchronous reset.
// rise is combinational from d and the registered copy q.
module rise_detect (
    input  logic timer_clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise
);

    always_ff @(posedge timer_clk) begin
        if (rst) q <= 1'b0;
        else     q <= d;
    end

    assign rise = d & ~q;

endmodule

// File: rtl/round_controller.sv
// Multi-round game sequencer: holds/releases the countdown timer,
// tracks rounds, accumulates a saturating time-bonus score.
module round_controller
    import round_pkg::*;
#(
    parameter int ROUND_TIME  = round_pkg::ROUND_TIME,
    parameter int NUM_ROUNDS  = 5,
    parameter int LEAD_IN     = 3,
    parameter int HOLD_CYCLES = 2,
    parameter int WARN_THRESH = 5,
    parameter int SCORE_W     = SCORE_W_DEF
) (
    input  logic               timer_clk,
    input  logic               rst,
    input  logic               start,
    input  logic               solved,
    input  logic [5:0]         time_remaining,
    input  logic               game_end,
    output logic               timer_rst,
    output logic [2:0]         phase,
    output logic [1:0]         lead_count,
    output logic [3:0]         round_num,
    output logic [SCORE_W-1:0] score,
    output logic               warn,
    output logic               done
);

    localparam logic [1:0]         LEAD_CNT = 2'(LEAD_IN);
    localparam logic [2:0]         HOLD_CNT = 3'(HOLD_CYCLES);
    localparam logic [3:0]         LAST_RND = 4'(NUM_ROUNDS);
    localparam logic [5:0]         WARN_LVL = 6'(WARN_THRESH);
    localparam logic [SCORE_W-1:0] SAT      = SCORE_W'(score_max(SCORE_W));

    logic               start_q;
    logic               start_rise;
    logic [2:0]         hold_cnt;
    logic [SCORE_W:0]   sum;
    logic [SCORE_W-1:0] sum_sat;
    logic               low_time;

    rise_detect u_rise (
        .timer_clk (timer_clk),
        .rst       (rst),
        .d         (start),
        .q         (start_q),
        .rise      (start_rise)
    );

    // One extra bit catches the carry so the add can clamp instead of wrap
    assign sum      = {1'b0, score} + (SCORE_W+1)'(time_remaining);
    assign sum_sat  = sum[SCORE_W] ? SAT : sum[SCORE_W-1:0];
    assign low_time = (time_remaining != 6'd0)
                    && (time_remaining <= WARN_LVL);

    always_ff @(posedge timer_clk) begin
        if (rst) begin
            phase      <= PH_IDLE;
            timer_rst  <= 1'b1;
            round_num  <= 4'd0;
            score      <= '0;
            lead_count <= 2'd0;
            hold_cnt   <= 3'd0;
            warn       <= 1'b0;
            done       <= 1'b0;
        end else begin
            warn <= 1'b0;
            unique case (phase)
                PH_IDLE, PH_OVER: begin
                    timer_rst <= 1'b1;
                    if (start_rise) begin
                        phase      <= PH_LEAD_IN;
                        lead_count <= LEAD_CNT;
                        round_num  <= 4'd1;
                        score      <= '0;
                        done       <= 1'b0;
                    end
                end
                PH_LEAD_IN: begin
                    if (lead_count == 2'd1) begin
                        phase      <= PH_PLAY;
                        lead_count <= 2'd0;
                        timer_rst  <= 1'b0;
                    end else begin
                        lead_count <= lead_count - 2'd1;
                    end
                end
                PH_PLAY: begin
                    // Expiry wins over a late answer in the same cycle
                    if (game_end || solved) begin
                        if (!game_end) score <= sum_sat;
                        phase     <= PH_HOLD;
                        timer_rst <= 1'b1;
                        hold_cnt  <= HOLD_CNT;
                    end else begin
                        warn <= low_time;
                    end
                end
                PH_HOLD: begin
                    if (hold_cnt == 3'd1) begin
                        if (round_num == LAST_RND) begin
                            phase <= PH_OVER;
                            done  <= 1'b1;
                        end else begin
                            round_num  <= round_num + 4'd1;
                            phase      <= PH_LEAD_IN;
                            lead_count <= LEAD_CNT;
                        end
                    end else begin
                        hold_cnt <= hold_cnt - 3'd1;
                    end
                end
                default: begin
                    phase     <= PH_IDLE;
                    timer_rst <= 1'b1;
                end
            endcase
        end
    end

    a_time_bound: assert property (
        @(posedge timer_clk) disable iff (rst)
        (phase != PH_PLAY) || (time_remaining <= 6'(ROUND_TIME))
    );

endmodule

// File: tb/tb_round_controller.sv
// Randomized bench for round_controller against a phase/age model.
// A narrow-score second instance exercises saturation.
module tb_round_controller;
    import round_pkg::*;

    localparam int L_IN   = 3;
    localparam int HOLD   = 2;
    localparam int NRND   = 5;
    localparam int WARN   = 5;
    localparam int SMAX_S = 31;

    logic       timer_clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       solved = 1'b0;
    logic [5:0] time_remaining = 6'd20;
    logic       game_end = 1'b0;

    logic       timer_rst, warn, done;
    logic [2:0] phase;
    logic [1:0] lead_count;
    logic [3:0] round_num;
    logic [7:0] score;

    logic       timer_rst_s, warn_s, done_s;
    logic [2:0] phase_s;
    logic [1:0] lead_count_s;
    logic [3:0] round_num_s;
    logic [4:0] score_s;

    always #5 timer_clk = ~timer_clk;

    round_controller dut (
        .timer_clk      (timer_clk),
        .rst            (rst),
        .start          (start),
        .solved         (solved),
        .time_remaining (time_remaining),
        .game_end       (game_end),
        .timer_rst      (timer_rst),
        .phase          (phase),
        .lead_count     (lead_count),
        .round_num      (round_num),
        .score          (score),
        .warn           (warn),
        .done           (done)
    );

    round_controller #(.SCORE_W(5)) dut_s (
        .timer_clk      (timer_clk),
        .rst            (rst),
        .start          (start),
        .solved         (solved),
        .time_remaining (time_remaining),
        .game_end       (game_end),
        .timer_rst      (timer_rst_s),
        .phase          (phase_s),
        .lead_count     (lead_count_s),
        .round_num      (round_num_s),
        .score          (score_s),
        .warn           (warn_s),
        .done           (done_s)
    );

    int n_cmp = 0;
    int n_err = 0;

    int m_phase = 0, m_age = 0, m_round = 0;
    int m_score = 0, m_score_s = 0;
    int m_warn = 0, m_done = 0, m_trst = 1, m_sq = 0;
    int tr = 20, dec = 1;

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     tag, obs, exp, $time);
        end
    endtask

    task automatic enter(input int p);
        m_phase = p;
        m_age   = 0;
    endtask

    function automatic int min_i(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // Spec-level model: each phase lasts a fixed number of cycles
    task automatic model_step();
        bit rise;
        rise = start && (m_sq == 0);
        m_sq = int'(start);
        if (rst) begin
            enter(0);
            m_round = 0; m_score = 0; m_score_s = 0;
            m_warn = 0; m_done = 0; m_sq = 0;
        end else begin
            m_warn = 0;
            case (m_phase)
                0, 4: if (rise) begin
                    enter(1);
                    m_round = 1; m_score = 0; m_score_s = 0; m_done = 0;
                end
                1: if (m_age == L_IN - 1) enter(2); else m_age++;
                2: begin
                    if (game_end) enter(3);
                    else if (solved) begin
                        m_score   = min_i(m_score + tr, SCORE_MAX);
                        m_score_s = min_i(m_score_s + tr, SMAX_S);
                        enter(3);
                    end else begin
                        m_warn = (tr > 0 && tr <= WARN) ? 1 : 0;
                        m_age++;
                    end
                end
                3: if (m_age == HOLD - 1) begin
                    if (m_round == NRND) begin
                        enter(4); m_done = 1;
                    end else begin
                        m_round++; enter(1);
                    end
                end else m_age++;
                default: enter(0);
            endcase
        end
        m_trst = (m_phase != 2) ? 1 : 0;
    endtask

    task automatic compare_all();
        int m_lead;
        m_lead = (m_phase == 1) ? L_IN - m_age : 0;
        check("phase", int'(phase), m_phase);
        check("lead", int'(lead_count), m_lead);
        check("round", int'(round_num), m_round);
        check("score", int'(score), m_score);
        check("warn", int'(warn), m_warn);
        check("done", int'(done), m_done);
        check("trst", int'(timer_rst), m_trst);
        check("s_phase", int'(phase_s), m_phase);
        check("s_lead", int'(lead_count_s), m_lead);
        check("s_round", int'(round_num_s), m_round);
        check("s_score", int'(score_s), m_score_s);
        check("s_warn", int'(warn_s), m_warn);
        check("s_done", int'(done_s), m_done);
        check("s_trst", int'(timer_rst_s), m_trst);
    endtask

    task automatic tick();
        int pre_trst;
        @(posedge timer_clk);
        #1;
        pre_trst = m_trst;
        model_step();
        compare_all();
        if (pre_trst != 0) tr = ROUND_TIME;
        else tr = (tr > dec) ? tr - dec : 0;
        time_remaining = 6'(tr);
        game_end = (tr == 0);
    endtask

    task automatic wait_play();
        for (int i = 0; i < 40 && m_phase != 2; i++) tick();
        check("reach_play", int'(phase), 2);
    endtask

    task automatic run_to_tr(input int t);
        for (int i = 0; i < 40 && tr != t; i++) tick();
        check("reach_tr", int'(time_remaining), t);
    endtask

    initial begin
        int sc0, r0;
        rst = 1'b1;
        tick(); tick();
        check("rst_phase", int'(phase), 0);
        check("rst_trst", int'(timer_rst), 1);
        rst = 1'b0;
        tick();
        // Round 1: lead-in then solve at 14
        start = 1'b1;
        tick();
        check("lead_first", int'(lead_count), 3);
        tick(); tick();
        check("lead_last", int'(lead_count), 1);
        tick();
        check("play_entry", int'(phase), 2);
        run_to_tr(14);
        solved = 1'b1;
        tick();
        check("solve_score", int'(score), 14);
        solved = 1'b0;
        tick(); tick();
        check("next_round", int'(round_num), 2);
        // Round 2: timeout with warnings
        wait_play();
        run_to_tr(0);
        tick();
        check("ge_hold", int'(phase), 3);
        check("ge_score", int'(score), 14);
        // Round 3: solve and expiry together
        wait_play();
        run_to_tr(0);
        solved = 1'b1;
        tick();
        check("tie_score", int'(score), 14);
        solved = 1'b0;
        // Round 4: immediate solve saturates the narrow score
        wait_play();
        solved = 1'b1;
        tick();
        check("sat_score", int'(score_s), SMAX_S);
        check("wide_score", int'(score), 34);
        solved = 1'b0;
        // Round 5 then game over, start still held high
        wait_play();
        run_to_tr(0);
        for (int i = 0; i < 12; i++) tick();
        check("over_phase", int'(phase), 4);
        check("over_done", int'(done), 1);
        start = 1'b0;
        tick();
        start = 1'b1;
        tick();
        check("restart_score", int'(score), 0);
        check("restart_round", int'(round_num), 1);
        // Reset in the middle of play
        wait_play();
        run_to_tr(9);
        rst = 1'b1;
        tick();
        check("midrst_phase", int'(phase), 0);
        check("midrst_trst", int'(timer_rst), 1);
        rst = 1'b0;
        tick();
        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            r0  = m_round;
            dec = $urandom_range(0, 2);
            if ($urandom_range(0, 5) == 0) start = ~start;
            if ($urandom_range(0, 7) == 0) solved = 1'b1;
            rst = ($urandom_range(0, 299) == 0);
            tick();
            if (m_round != r0 || $urandom_range(0, 15) == 0)
                solved = 1'b0;
        end
        sc0 = n_cmp;
        if (sc0 == 0) check("no_compares", 0, 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
